fetch_stage: RTL

- Instruction-fetch stage plus IF/ID boundary of the pipelined miniRV core.
- Holds the fetch PC, drives a synchronous (1-cycle-latency) IROM, and presents a tagged instruction (pc, pc+4, inst, valid) to the decode stage, whose controller consumes id_inst.
- Obeys stall from the hazard unit and redirect (taken branch/jal/jalr) from EX.
- Inserts NOP bubbles on reset and after every redirect.

---
 rtl/fetch_stage_pkg.sv | 17 +
 rtl/fetch_pc_reg.sv | 40 ++++
 rtl/fetch_stage.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the miniRV instruction-fetch stage.
package fetch_stage_pkg;

  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_FILL = 2'd0,
    IF_RUN  = 2'd1,
    IF_HOLD = 2'd2
  } if_state_e;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch PC register: redirect > stall > sequential +4 advance.
module fetch_pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_f
);

  logic [31:0] pc_f_d;
  logic [31:0] pc_f_q;
  logic        unused_lsb;

  assign unused_lsb = ^redirect_pc[1:0];

  always_comb begin
    pc_f_d = pc_f_q;
    if (redirect) begin
      pc_f_d = align_pc(redirect_pc);
    end else if (!stall) begin
      pc_f_d = pc_f_q + 32'd4;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      pc_f_q <= align_pc(RESET_PC);
    end else begin
      pc_f_q <= pc_f_d;
    end
  end

  assign pc_f = pc_f_q;

endmodule

// File: rtl/fetch_stage.sv
// miniRV fetch stage and IF/ID boundary with bubble insertion on reset/redirect.
// Optional perf counters are enabled with `define IF_PERF_CNT_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0]  RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned  IROM_AW  = 14
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  output logic [IROM_AW-1:0] irom_addr,
  input  logic [31:0]        irom_inst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc4,
  output logic [31:0]        id_inst,
  output logic               id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_bubble_cnt
`endif
);

  logic [31:0] pc_f;
  logic        unused_pc_bits;

  if_state_e   state_d, state_q;
  logic [31:0] id_pc_d, id_pc_q;
  logic [31:0] hold_inst_d, hold_inst_q;

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .cpu_clk     (cpu_clk),
    .cpu_rst     (cpu_rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc_f        (pc_f)
  );

  // IROM sees only the word index; upper and byte bits are don't-care.
  assign irom_addr      = pc_f[IROM_AW+1:2];
  assign unused_pc_bits = ^{pc_f[31:IROM_AW+2], pc_f[1:0]};

  // Next state for the IF/ID tag, capture register and fill/run/hold FSM.
  always_comb begin
    state_d     = state_q;
    id_pc_d     = id_pc_q;
    hold_inst_d = hold_inst_q;
    if (redirect) begin
      state_d     = IF_FILL;
      hold_inst_d = '0;
    end else if (stall) begin
      if (state_q == IF_RUN) begin
        state_d     = IF_HOLD;
        hold_inst_d = irom_inst;
      end
    end else begin
      state_d = IF_RUN;
      id_pc_d = pc_f;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q     <= IF_FILL;
      id_pc_q     <= align_pc(RESET_PC);
      hold_inst_q <= '0;
    end else begin
      state_q     <= state_d;
      id_pc_q     <= id_pc_d;
      hold_inst_q <= hold_inst_d;
    end
  end

  // In RUN the IROM output already belongs to id_pc (one-cycle read latency).
  always_comb begin
    id_valid = (state_q != IF_FILL);
    id_pc    = id_pc_q;
    id_pc4   = id_pc_q + 32'd4;
    case (state_q)
      IF_RUN:  id_inst = irom_inst;
      IF_HOLD: id_inst = hold_inst_q;
      default: id_inst = INST_NOP;
    endcase
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_d, perf_fetch_q;
  logic [31:0] perf_bubble_d, perf_bubble_q;

  always_comb begin
    perf_fetch_d  = perf_fetch_q;
    perf_bubble_d = perf_bubble_q;
    if (!stall) begin
      if (state_q != IF_FILL) begin
        perf_fetch_d = perf_fetch_q + 32'd1;
      end else begin
        perf_bubble_d = perf_bubble_q + 32'd1;
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      perf_fetch_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      perf_fetch_q  <= perf_fetch_d;
      perf_bubble_q <= perf_bubble_d;
    end
  end

  assign perf_fetch_cnt  = perf_fetch_q;
  assign perf_bubble_cnt = perf_bubble_q;
`endif

endmodule
